// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with burst, undefined-length INCR and locked-sequence protection.
// Master 0 is the park master; HGRANT and HMASTER are registered and advance only on HREADY.

module ahb_bus_arbiter_chk #(
  parameter int NUM_MASTERS = 4,
  parameter int MIDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic                   i_hclk,
  input  logic                   i_hreset,
  input  logic [NUM_MASTERS-1:0] i_hgrant,
  input  logic [MIDX_W-1:0]      i_hmaster
);

  localparam logic [MIDX_W:0] NUM_M = NUM_MASTERS[MIDX_W:0];

  a_grant_onehot: assert property (@(posedge i_hclk) disable iff (i_hreset)
    $onehot(i_hgrant));

  a_hmaster_range: assert property (@(posedge i_hclk) disable iff (i_hreset)
    ({1'b0, i_hmaster} < NUM_M));

endmodule

module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MIDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic                   i_hclk,
  input  logic                   i_hreset,
  input  logic [NUM_MASTERS-1:0] i_hbusreq,
  input  logic [NUM_MASTERS-1:0] i_hlock,
  input  logic [1:0]             i_htrans,
  input  logic [2:0]             i_hburst,
  input  logic                   i_hready,
  input  logic                   i_hresp,
  output logic [NUM_MASTERS-1:0] o_hgrant,
  output logic [MIDX_W-1:0]      o_hmaster,
  output logic                   o_hmastlock
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [NUM_MASTERS-1:0] GRANT_PARK = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [MIDX_W:0]        NUM_M      = NUM_MASTERS[MIDX_W:0];

  function automatic logic [MIDX_W-1:0] f_onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [MIDX_W-1:0] idx;
    idx = {MIDX_W{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = idx | ({MIDX_W{oh[i]}} & i[MIDX_W-1:0]);
    end
    return idx;
  endfunction

  // Remaining beats after the NONSEQ beat of a fixed-length burst.
  function automatic logic [3:0] f_burst_beats(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

  logic [NUM_MASTERS-1:0] r_hgrant;
  logic [MIDX_W-1:0]      r_hmaster;
  logic                   r_hmastlock;
  logic [3:0]             r_beat_cnt;
  logic                   r_incr_act;
  logic                   r_lock_hold;

  logic [MIDX_W-1:0]      w_owner_idx;
  logic                   w_incr_hold;
  logic                   w_arb_ok;
  logic                   w_found;
  logic [MIDX_W-1:0]      w_winner_idx;
  logic [MIDX_W:0]        w_cand;
  logic [NUM_MASTERS-1:0] w_next_grant;
  logic                   w_grant_moves;
  logic                   w_winner_lock;

  assign w_owner_idx = f_onehot_to_idx(r_hgrant);
  assign w_incr_hold = r_incr_act & i_hbusreq[w_owner_idx];
  assign w_arb_ok    = i_hready & (i_hresp |
                       ((r_beat_cnt <= 4'd1) & ~r_lock_hold & ~w_incr_hold));

  // Scan from owner+k down to owner+1 so the nearest requester after the owner wins; owner is last.
  always_comb begin
    w_found      = 1'b0;
    w_winner_idx = {MIDX_W{1'b0}};
    w_cand       = {(MIDX_W+1){1'b0}};
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      w_cand = {1'b0, w_owner_idx} + k[MIDX_W:0];
      if (w_cand >= NUM_M) begin
        w_cand = w_cand - NUM_M;
      end else begin
        w_cand = w_cand;
      end
      if (i_hbusreq[w_cand[MIDX_W-1:0]]) begin
        w_found      = 1'b1;
        w_winner_idx = w_cand[MIDX_W-1:0];
      end else begin
        w_found      = w_found;
        w_winner_idx = w_winner_idx;
      end
    end
  end

  assign w_next_grant  = w_found ? (GRANT_PARK << w_winner_idx) : GRANT_PARK;
  assign w_grant_moves = w_arb_ok & (w_next_grant != r_hgrant);
  assign w_winner_lock = w_found & i_hlock[w_winner_idx];

  // Grant, handover, beat counting and lock tracking; everything advances only on HREADY.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_hgrant    <= GRANT_PARK;
      r_hmaster   <= {MIDX_W{1'b0}};
      r_hmastlock <= 1'b0;
      r_beat_cnt  <= 4'd0;
      r_incr_act  <= 1'b0;
      r_lock_hold <= 1'b0;
    end else if (i_hready) begin
      r_hmaster   <= w_owner_idx;
      r_hmastlock <= r_lock_hold;

      if (w_arb_ok) begin
        r_hgrant <= w_next_grant;
      end else begin
        r_hgrant <= r_hgrant;
      end

      if (i_hresp) begin
        r_beat_cnt <= 4'd0;
      end else begin
        case (i_htrans)
          HTRANS_NONSEQ: r_beat_cnt <= f_burst_beats(i_hburst);
          HTRANS_SEQ:    r_beat_cnt <= (r_beat_cnt != 4'd0) ? (r_beat_cnt - 4'd1) : r_beat_cnt;
          default:       r_beat_cnt <= r_beat_cnt;
        endcase
      end

      // A new INCR burst on a handover edge belongs to the old owner, so the move wins.
      if (i_hresp || w_grant_moves) begin
        r_incr_act <= 1'b0;
      end else if (i_htrans == HTRANS_NONSEQ && i_hburst == HBURST_INCR) begin
        r_incr_act <= 1'b1;
      end else if (i_htrans == HTRANS_IDLE) begin
        r_incr_act <= 1'b0;
      end else begin
        r_incr_act <= r_incr_act;
      end

      if (i_hresp) begin
        r_lock_hold <= 1'b0;
      end else if (w_arb_ok) begin
        r_lock_hold <= w_winner_lock;
      end else if (!i_hlock[w_owner_idx]) begin
        r_lock_hold <= 1'b0;
      end else begin
        r_lock_hold <= r_lock_hold;
      end
    end else begin
      r_hgrant    <= r_hgrant;
      r_hmaster   <= r_hmaster;
      r_hmastlock <= r_hmastlock;
      r_beat_cnt  <= r_beat_cnt;
      r_incr_act  <= r_incr_act;
      r_lock_hold <= r_lock_hold;
    end
  end

  assign o_hgrant    = r_hgrant;
  assign o_hmaster   = r_hmaster;
  assign o_hmastlock = r_hmastlock;

  ahb_bus_arbiter_chk #(
    .NUM_MASTERS (NUM_MASTERS),
    .MIDX_W      (MIDX_W)
  ) u_chk (
    .i_hclk    (i_hclk),
    .i_hreset  (i_hreset),
    .i_hgrant  (r_hgrant),
    .i_hmaster (r_hmaster)
  );

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: reset, round-robin, burst/INCR/lock protection, error abort.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;

  logic       clk = 1'b0;
  logic       hreset = 1'b1;
  logic [3:0] hbusreq = 4'b0000;
  logic [3:0] hlock = 4'b0000;
  logic [1:0] htrans = 2'b00;
  logic [2:0] hburst = 3'b000;
  logic       hready = 1'b1;
  logic       hresp = 1'b0;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(.NUM_MASTERS(4), .MIDX_W(2)) dut (
    .i_hclk      (clk),
    .i_hreset    (hreset),
    .i_hbusreq   (hbusreq),
    .i_hlock     (hlock),
    .i_htrans    (htrans),
    .i_hburst    (hburst),
    .i_hready    (hready),
    .i_hresp     (hresp),
    .o_hgrant    (hgrant),
    .o_hmaster   (hmaster),
    .o_hmastlock (hmastlock)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    hreset  = 1'b1;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    htrans  = T_IDLE;
    hburst  = B_SINGLE;
    hready  = 1'b1;
    hresp   = 1'b0;
    tick();
    hreset  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (hgrant !== 4'b0001) begin n_fails++; $display("FAIL reset_grant: got %b want %b", hgrant, 4'b0001); end
    n_checks++;
    if (hmaster !== 2'd0) begin n_fails++; $display("FAIL reset_hmaster: got %0d want 0", hmaster); end
    n_checks++;
    if (hmastlock !== 1'b0) begin n_fails++; $display("FAIL reset_hmastlock: got %b want 0", hmastlock); end
    tick();
    n_checks++;
    if (hgrant !== 4'b0001) begin n_fails++; $display("FAIL reset_park: got %b want %b", hgrant, 4'b0001); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [4];
    logic [1:0] exp_m [4];
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_m = '{2'd0, 2'd1, 2'd2, 2'd3};
    apply_reset();
    hbusreq = 4'b1111;
    htrans  = T_NONSEQ;
    hburst  = B_SINGLE;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (hgrant !== exp_g[i]) begin n_fails++; $display("FAIL rr_grant[%0d]: got %b want %b", i, hgrant, exp_g[i]); end
      n_checks++;
      if (hmaster !== exp_m[i]) begin n_fails++; $display("FAIL rr_hmaster[%0d]: got %0d want %0d", i, hmaster, exp_m[i]); end
    end
    hready = 1'b0;
    tick();
    n_checks++;
    if (hgrant !== 4'b0001) begin n_fails++; $display("FAIL rr_stall_grant: got %b want %b", hgrant, 4'b0001); end
    n_checks++;
    if (hmaster !== 2'd3) begin n_fails++; $display("FAIL rr_stall_hmaster: got %0d want 3", hmaster); end
    hready  = 1'b1;
    hbusreq = 4'b0100;
    tick();
    n_checks++;
    if (hgrant !== 4'b0100) begin n_fails++; $display("FAIL rr_single_req: got %b want %b", hgrant, 4'b0100); end
    hbusreq = 4'b0000;
    tick();
    n_checks++;
    if (hgrant !== 4'b0001) begin n_fails++; $display("FAIL rr_park: got %b want %b", hgrant, 4'b0001); end
  endtask

  task automatic test_incr4();
    apply_reset();
    hbusreq = 4'b0010;
    tick();
    n_checks++;
    if (hgrant !== 4'b0010) begin n_fails++; $display("FAIL incr4_setup: got %b want %b", hgrant, 4'b0010); end
    htrans = T_NONSEQ;
    hburst = B_INCR4;
    tick();
    hbusreq = 4'b1111;
    htrans  = T_SEQ;
    hready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) hready = 1'b1;
      tick();
      n_checks++;
      if (hgrant !== 4'b0010) begin n_fails++; $display("FAIL incr4_hold[%0d]: got %b want %b", i, hgrant, 4'b0010); end
    end
    tick();
    n_checks++;
    if (hgrant !== 4'b0100) begin n_fails++; $display("FAIL incr4_handover: got %b want %b", hgrant, 4'b0100); end
    n_checks++;
    if (hmaster !== 2'd1) begin n_fails++; $display("FAIL incr4_hmaster: got %0d want 1", hmaster); end
  endtask

  task automatic test_undef_incr();
    apply_reset();
    hbusreq = 4'b1000;
    tick();
    n_checks++;
    if (hgrant !== 4'b1000) begin n_fails++; $display("FAIL incr_setup: got %b want %b", hgrant, 4'b1000); end
    htrans = T_NONSEQ;
    hburst = B_INCR;
    tick();
    hbusreq = 4'b1001;
    htrans  = T_SEQ;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (hgrant !== 4'b1000) begin n_fails++; $display("FAIL incr_hold[%0d]: got %b want %b", i, hgrant, 4'b1000); end
    end
    hbusreq = 4'b0001;
    tick();
    n_checks++;
    if (hgrant !== 4'b0001) begin n_fails++; $display("FAIL incr_release: got %b want %b", hgrant, 4'b0001); end
    n_checks++;
    if (hmaster !== 2'd3) begin n_fails++; $display("FAIL incr_hmaster: got %0d want 3", hmaster); end
  endtask

  task automatic test_lock();
    apply_reset();
    hbusreq = 4'b1111;
    hlock   = 4'b0100;
    htrans  = T_NONSEQ;
    hburst  = B_SINGLE;
    tick();
    tick();
    n_checks++;
    if (hgrant !== 4'b0100 || hmastlock !== 1'b0) begin
      n_fails++; $display("FAIL lock_grant: got %b/%b want 0100/0", hgrant, hmastlock);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (hgrant !== 4'b0100 || hmaster !== 2'd2 || hmastlock !== 1'b1) begin
        n_fails++; $display("FAIL lock_hold[%0d]: got g=%b m=%0d l=%b want g=0100 m=2 l=1", i, hgrant, hmaster, hmastlock);
      end
    end
    hlock = 4'b0000;
    tick();
    n_checks++;
    if (hgrant !== 4'b0100 || hmastlock !== 1'b1) begin
      n_fails++; $display("FAIL lock_release_edge: got g=%b l=%b want g=0100 l=1", hgrant, hmastlock);
    end
    tick();
    n_checks++;
    if (hgrant !== 4'b1000 || hmastlock !== 1'b0) begin
      n_fails++; $display("FAIL lock_resume: got g=%b l=%b want g=1000 l=0", hgrant, hmastlock);
    end
  endtask

  task automatic test_error();
    apply_reset();
    hbusreq = 4'b0010;
    tick();
    htrans = T_NONSEQ;
    hburst = B_INCR8;
    tick();
    htrans = T_SEQ;
    tick();
    tick();
    n_checks++;
    if (dut.r_beat_cnt !== 4'd5) begin n_fails++; $display("FAIL err_setup_cnt: got %0d want 5", dut.r_beat_cnt); end
    hbusreq = 4'b0011;
    hready  = 1'b0;
    hresp   = 1'b1;
    tick();
    n_checks++;
    if (hgrant !== 4'b0010) begin n_fails++; $display("FAIL err_wait_grant: got %b want %b", hgrant, 4'b0010); end
    hready = 1'b1;
    tick();
    hresp = 1'b0;
    n_checks++;
    if (hgrant !== 4'b0001) begin n_fails++; $display("FAIL err_grant: got %b want %b", hgrant, 4'b0001); end
    n_checks++;
    if (dut.r_beat_cnt !== 4'd0) begin n_fails++; $display("FAIL err_cnt: got %0d want 0", dut.r_beat_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    hbusreq = 4'b0100;
    tick();
    htrans = T_NONSEQ;
    hburst = B_INCR8;
    tick();
    hbusreq = 4'b1111;
    htrans  = T_SEQ;
    tick();
    tick();
    n_checks++;
    if (dut.r_beat_cnt !== 4'd5 || hmaster !== 2'd2) begin
      n_fails++; $display("FAIL rst_mid_setup: got cnt=%0d m=%0d want cnt=5 m=2", dut.r_beat_cnt, hmaster);
    end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    n_checks++;
    if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmastlock !== 1'b0) begin
      n_fails++; $display("FAIL rst_mid: got g=%b m=%0d l=%b want g=0001 m=0 l=0", hgrant, hmaster, hmastlock);
    end
    n_checks++;
    if (dut.r_beat_cnt !== 4'd0) begin n_fails++; $display("FAIL rst_mid_cnt: got %0d want 0", dut.r_beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_incr4();
    test_undef_incr();
    test_lock();
    test_error();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
